// File: rtl/neopixel_frame_ctrl.sv
// WS2812 strip controller: loads a double-buffered RGB frame from a UART byte
// stream and serialises it in GRB order with WS2812 bit timing on one data line.
module neopixel_frame_ctrl #(
    parameter int NUM_PIXELS     = 10,
    parameter int T_BIT          = 15,
    parameter int T0H            = 5,
    parameter int T1H            = 10,
    parameter int RESET_CYCLES   = 1000,
    parameter int REFRESH_CYCLES = 600000,
    parameter int RX_TIMEOUT     = 24000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       rx_overrun
);

    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CW = $clog2(T_BIT + 1);
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int FW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam int IW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] LAST_PIX   = PW'(NUM_PIXELS - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [FW-1:0] REF_MAX    = FW'(REFRESH_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(RX_TIMEOUT);
    localparam bit            REFRESH_EN = (REFRESH_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BIT   = 2'd2,
        LATCH = 2'd3
    } tx_state_t;

    tx_state_t state, state_next;

    // Frame buffer, one array per colour so each received byte is a plain write.
    logic [7:0] mem_r [2][NUM_PIXELS];
    logic [7:0] mem_g [2][NUM_PIXELS];
    logic [7:0] mem_b [2][NUM_PIXELS];

    logic          bank;
    logic          back_bank;
    logic          swap_pending;
    logic          have_frame;
    logic [1:0]    col_idx;
    logic [PW-1:0] wr_pix;
    logic [IW-1:0] idle_cnt;

    logic [PW-1:0] rd_pix;
    logic [23:0]   shift;
    logic [4:0]    bit_num;
    logic [CW-1:0] bit_cyc;
    logic [LW-1:0] latch_cnt;
    logic [FW-1:0] ref_cnt;

    logic wr_en;
    logic frame_complete;
    logic refresh_due;
    logic do_swap;

    assign back_bank      = ~bank;
    assign wr_en          = rx_valid && !swap_pending;
    assign frame_complete = wr_en && (col_idx == 2'd2) && (wr_pix == LAST_PIX);
    // A frame finishing loading this cycle beats a refresh that falls due now.
    assign refresh_due    = REFRESH_EN && have_frame && (ref_cnt == REF_MAX) && !frame_complete;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            case (col_idx)
                2'd0:    mem_r[back_bank][wr_pix] <= rx_byte;
                2'd1:    mem_g[back_bank][wr_pix] <= rx_byte;
                default: mem_b[back_bank][wr_pix] <= rx_byte;
            endcase
        end
    end

    // Loader: byte/pixel indices, swap request, overrun flag and resync timer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_idx      <= 2'd0;
            wr_pix       <= '0;
            swap_pending <= 1'b0;
            have_frame   <= 1'b0;
            rx_overrun   <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            rx_overrun <= rx_valid && swap_pending;
            if (rx_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            if (do_swap) begin
                swap_pending <= 1'b0;
            end
            if (wr_en) begin
                if (col_idx == 2'd2) begin
                    col_idx <= 2'd0;
                    if (wr_pix == LAST_PIX) begin
                        wr_pix       <= '0;
                        swap_pending <= 1'b1;
                        have_frame   <= 1'b1;
                    end else begin
                        wr_pix <= wr_pix + PW'(1);
                    end
                end else begin
                    col_idx <= col_idx + 2'd1;
                end
            end else if (!rx_valid && idle_cnt == IDLE_MAX) begin
                col_idx <= 2'd0;
                wr_pix  <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        do_swap    = 1'b0;
        dout       = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (swap_pending) begin
                    do_swap    = 1'b1;
                    state_next = LOAD;
                end else if (refresh_due) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = BIT;
            end
            BIT: begin
                dout = shift[23] ? (bit_cyc < T1H_C) : (bit_cyc < T0H_C);
                if (bit_cyc == BIT_LAST && bit_num == 5'd23) begin
                    state_next = (rd_pix == LAST_PIX) ? LATCH : LOAD;
                end
            end
            LATCH: begin
                if (latch_cnt == LATCH_LAST) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bank      <= 1'b0;
            rd_pix    <= '0;
            shift     <= '0;
            bit_num   <= 5'd0;
            bit_cyc   <= '0;
            latch_cnt <= '0;
            ref_cnt   <= '0;
        end else begin
            state <= state_next;
            if (do_swap) begin
                bank <= ~bank;
            end
            if (state == IDLE && state_next == IDLE) begin
                if (ref_cnt != REF_MAX) begin
                    ref_cnt <= ref_cnt + FW'(1);
                end
            end else begin
                ref_cnt <= '0;
            end
            case (state)
                LOAD: begin
                    shift   <= {mem_g[bank][rd_pix], mem_r[bank][rd_pix], mem_b[bank][rd_pix]};
                    bit_num <= 5'd0;
                    bit_cyc <= '0;
                end
                BIT: begin
                    if (bit_cyc == BIT_LAST) begin
                        bit_cyc <= '0;
                        shift   <= {shift[22:0], 1'b0};
                        bit_num <= bit_num + 5'd1;
                        if (bit_num == 5'd23) begin
                            rd_pix <= (rd_pix == LAST_PIX) ? '0 : rd_pix + PW'(1);
                        end
                    end else begin
                        bit_cyc <= bit_cyc + CW'(1);
                    end
                end
                LATCH: begin
                    latch_cnt <= (latch_cnt == LATCH_LAST) ? '0 : latch_cnt + LW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Bench for neopixel_frame_ctrl: two 2-pixel instances (refresh off / refresh 2000)
// with a dout decoder that checks pulse widths and pops expected GRB words.
module tb_neopixel_frame_ctrl;

    localparam int T0H = 5;
    localparam int T1H = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       rx_valid_a, rx_valid_b;
    logic [7:0] rx_byte_a, rx_byte_b;
    logic       dout_a, dout_b, busy_a, busy_b, fd_a, fd_b, ovr_a, ovr_b;

    neopixel_frame_ctrl #(.NUM_PIXELS(2), .REFRESH_CYCLES(0)) u_a (
        .CLK(clk), .RST(rst_a), .rx_byte(rx_byte_a), .rx_valid(rx_valid_a),
        .dout(dout_a), .busy(busy_a), .frame_done(fd_a), .rx_overrun(ovr_a)
    );

    neopixel_frame_ctrl #(.NUM_PIXELS(2), .REFRESH_CYCLES(2000)) u_b (
        .CLK(clk), .RST(rst_b), .rx_byte(rx_byte_b), .rx_valid(rx_valid_b),
        .dout(dout_b), .busy(busy_b), .frame_done(fd_b), .rx_overrun(ovr_b)
    );

    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int hi_cnt[2], nbits[2], pix_cnt[2], rise_cnt[2], fd_cnt[2], ovr_cnt[2];
    int last_fall[2], fd_cyc[2], fd_gap[2], idle_gap[2];
    bit prev_d[2], busy_seen[2], fd_armed[2];
    logic [23:0] word[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_ch(input int ch, input logic d, input logic b, input logic fd,
                          input logic ov, input logic r);
        logic [23:0] exp_w;
        bit have_exp;
        if (r) begin
            hi_cnt[ch] = 0;
            nbits[ch]  = 0;
            prev_d[ch] = 1'b0;
            return;
        end
        if (b) busy_seen[ch] = 1'b1;
        if (ov) ovr_cnt[ch]++;
        if (fd) begin
            fd_cnt[ch]++;
            fd_cyc[ch]   = cyc;
            fd_gap[ch]   = cyc - last_fall[ch];
            fd_armed[ch] = 1'b1;
        end
        if (d && !prev_d[ch]) begin
            rise_cnt[ch]++;
            if (fd_armed[ch]) begin
                idle_gap[ch] = cyc - fd_cyc[ch];
                fd_armed[ch] = 1'b0;
            end
        end
        if (d) begin
            hi_cnt[ch]++;
        end else if (hi_cnt[ch] != 0) begin
            last_fall[ch] = cyc;
            tests++;
            assert (hi_cnt[ch] == T0H || hi_cnt[ch] == T1H) else begin
                fails++;
                $error("FAIL pulse_width ch%0d observed=%0d expected=%0d or %0d", ch, hi_cnt[ch], T0H, T1H);
            end
            word[ch]   = {word[ch][22:0], (hi_cnt[ch] == T1H)};
            hi_cnt[ch] = 0;
            nbits[ch]++;
            if (nbits[ch] == 24) begin
                nbits[ch] = 0;
                pix_cnt[ch]++;
                have_exp = 1'b0;
                exp_w    = '0;
                if (ch == 0 && exp_q0.size() > 0) begin
                    exp_w = exp_q0.pop_front();
                    have_exp = 1'b1;
                end else if (ch == 1 && exp_q1.size() > 0) begin
                    exp_w = exp_q1.pop_front();
                    have_exp = 1'b1;
                end
                tests++;
                assert (have_exp && word[ch] === exp_w) else begin
                    fails++;
                    $error("FAIL pixel ch%0d #%0d observed=%06h expected=%06h queued=%0d",
                           ch, pix_cnt[ch] - 1, word[ch], exp_w, have_exp);
                end
            end
        end
        prev_d[ch] = d;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon_ch(0, dout_a, busy_a, fd_a, ovr_a, rst_a);
        mon_ch(1, dout_b, busy_b, fd_b, ovr_b, rst_b);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [23:0] w);
        if (ch == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b);
        if (ch == 0) begin
            rx_byte_a  = b;
            rx_valid_a = 1'b1;
        end else begin
            rx_byte_b  = b;
            rx_valid_b = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    // Sends R,G,B of pixel 0 then pixel 1 and queues the GRB words to be seen on dout.
    task automatic send_frame(input int ch, input logic [7:0] r0, input logic [7:0] g0,
                              input logic [7:0] b0, input logic [7:0] r1,
                              input logic [7:0] g1, input logic [7:0] b1);
        send_byte(ch, r0);
        send_byte(ch, g0);
        send_byte(ch, b0);
        send_byte(ch, r1);
        send_byte(ch, g1);
        send_byte(ch, b1);
        push_exp(ch, {g0, r0, b0});
        push_exp(ch, {g1, r1, b1});
    endtask

    task automatic wait_pix(input int ch, input int target, input int budget);
        int n = 0;
        while (pix_cnt[ch] < target && n < budget) begin
            tick(1);
            n++;
        end
        check($sformatf("pixel_count_ch%0d", ch), pix_cnt[ch], target);
    endtask

    task automatic wait_fd(input int ch, input int target, input int budget);
        int n = 0;
        while (fd_cnt[ch] < target && n < budget) begin
            tick(1);
            n++;
        end
        check($sformatf("frame_done_count_ch%0d", ch), fd_cnt[ch], target);
    endtask

    task automatic pulse_rst_b();
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic [7:0] rb[6];

        rst_a = 1'b1;
        rst_b = 1'b1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        rx_byte_a  = '0;
        rx_byte_b  = '0;
        tick(3);

        check("reset_dout_a", dout_a, 1'b0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_fd_a", fd_a, 1'b0);
        check("reset_ovr_a", ovr_a, 1'b0);
        check("reset_dout_b", dout_b, 1'b0);
        check("reset_busy_b", busy_b, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // No frame loaded yet: the refresh interval elapsing must not start a transmission.
        tick(2100);
        check("noframe_busy_b", busy_seen[1], 1'b0);
        check("noframe_rise_b", rise_cnt[1], 0);
        check("noframe_rise_a", rise_cnt[0], 0);

        // Refresh: one frame on u_b is re-sent after every ~2000 idle cycles.
        send_frame(1, 8'h12, 8'h34, 8'h56, 8'hC3, 8'h5A, 8'h0F);
        push_exp(1, {8'h34, 8'h12, 8'h56});
        push_exp(1, {8'h5A, 8'hC3, 8'h0F});
        push_exp(1, {8'h34, 8'h12, 8'h56});
        push_exp(1, {8'h5A, 8'hC3, 8'h0F});
        wait_pix(1, 6, 15000);
        wait_fd(1, 3, 1200);
        check("refresh_gap_in_window", (idle_gap[1] >= 2000 && idle_gap[1] <= 2006), 1'b1);
        check("refresh_queue_empty", exp_q1.size(), 0);
        pulse_rst_b();

        // Reset in the middle of pixel 1 on u_b.
        send_frame(1, 8'hF0, 8'h0F, 8'hA5, 8'h5A, 8'hFF, 8'h81);
        n = 0;
        while (!(pix_cnt[1] == 7 && nbits[1] == 7) && n < 1000) begin
            tick(1);
            n++;
        end
        check("midframe_reached", (pix_cnt[1] == 7 && nbits[1] == 7), 1'b1);
        rst_b = 1'b1;
        tick(1);
        check("midframe_rst_dout", dout_b, 1'b0);
        check("midframe_rst_busy", busy_b, 1'b0);
        rst_b = 1'b0;
        check("midframe_pending_pixels", exp_q1.size(), 1);
        if (exp_q1.size() > 0) void'(exp_q1.pop_front());
        rises = rise_cnt[1];
        busy_seen[1] = 1'b0;
        tick(2600);
        check("after_rst_no_rise", rise_cnt[1], rises);
        check("after_rst_no_busy", busy_seen[1], 1'b0);
        send_frame(1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        wait_pix(1, 9, 2500);
        wait_fd(1, 4, 1200);
        pulse_rst_b();

        // Basic frame with latency and latch timing on u_a.
        send_frame(0, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00);
        check("lat_swap_busy", busy_a, 1'b0);
        check("lat_swap_dout", dout_a, 1'b0);
        tick(1);
        check("lat_load_busy", busy_a, 1'b1);
        check("lat_load_dout", dout_a, 1'b0);
        tick(1);
        check("lat_first_rise", dout_a, 1'b1);
        wait_pix(0, 2, 2000);
        wait_fd(0, 1, 1200);
        check("latch_low_cycles", fd_gap[0], 1009);
        rises = rise_cnt[0];
        tick(3000);
        check("norefresh_rise", rise_cnt[0], rises);
        check("norefresh_pixels", pix_cnt[0], 2);
        check("norefresh_fd", fd_cnt[0], 1);
        check("idle_busy_a", busy_a, 1'b0);

        // Partial frame, stream timeout, then a clean frame.
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        send_byte(0, 8'hCC);
        tick(24010);
        send_frame(0, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
        wait_pix(0, 4, 2500);
        wait_fd(0, 2, 1200);
        tick(3000);
        check("resync_pixels", pix_cnt[0], 4);
        check("resync_fd", fd_cnt[0], 2);

        // Frame B loaded while A transmits; further bytes are dropped as overruns.
        for (int i = 0; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
        send_frame(0, rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]);
        tick(50);
        check("frame_a_in_progress", busy_a, 1'b1);
        for (int i = 0; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
        send_frame(0, rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]);
        tick(2);
        check("frame_b_no_overrun", ovr_cnt[0], 0);
        send_byte(0, 8'hEE);
        check("overrun_pulse", ovr_a, 1'b1);
        send_byte(0, 8'hDD);
        send_byte(0, 8'hCC);
        tick(2);
        check("overrun_idle", ovr_a, 1'b0);
        check("overrun_count", ovr_cnt[0], 3);
        wait_pix(0, 8, 5000);
        wait_fd(0, 4, 1200);
        tick(200);
        check("after_b_pixels", pix_cnt[0], 8);

        // Dropped bytes must not have moved the load indices.
        for (int i = 0; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
        send_frame(0, rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]);
        wait_pix(0, 10, 2500);
        wait_fd(0, 5, 1200);

        check("queue_a_empty", exp_q0.size(), 0);
        check("queue_b_empty", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
